// File: rtl/mac_lut_age_ctrl_if.sv
// Host register and LUT direct-access ports of the MAC LUT aging controller.
// master = controller side, slave = host/LUT side.
interface mac_lut_age_ctrl_if #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH_BITS    = 4
);
  logic                         host_rd_req;
  logic [LUT_DEPTH_BITS-1:0]    host_rd_addr;
  logic                         host_rd_ack;
  logic [NUM_OUTPUT_QUEUES-1:0] host_rd_oq;
  logic                         host_rd_wr_protect;
  logic [47:0]                  host_rd_mac;

  logic                         host_wr_req;
  logic [LUT_DEPTH_BITS-1:0]    host_wr_addr;
  logic [NUM_OUTPUT_QUEUES-1:0] host_wr_oq;
  logic                         host_wr_protect;
  logic [47:0]                  host_wr_mac;
  logic                         host_wr_ack;

  logic                         lut_rd_req;
  logic [LUT_DEPTH_BITS-1:0]    lut_rd_addr;
  logic                         lut_rd_ack;
  logic [NUM_OUTPUT_QUEUES-1:0] lut_rd_oq;
  logic                         lut_rd_wr_protect;
  logic [47:0]                  lut_rd_mac;

  logic                         lut_wr_req;
  logic [LUT_DEPTH_BITS-1:0]    lut_wr_addr;
  logic [NUM_OUTPUT_QUEUES-1:0] lut_wr_oq;
  logic                         lut_wr_protect;
  logic [47:0]                  lut_wr_mac;
  logic                         lut_wr_ack;

  modport master (
    input  host_rd_req, host_rd_addr,
    output host_rd_ack, host_rd_oq, host_rd_wr_protect, host_rd_mac,
    input  host_wr_req, host_wr_addr, host_wr_oq, host_wr_protect, host_wr_mac,
    output host_wr_ack,
    output lut_rd_req, lut_rd_addr,
    input  lut_rd_ack, lut_rd_oq, lut_rd_wr_protect, lut_rd_mac,
    output lut_wr_req, lut_wr_addr, lut_wr_oq, lut_wr_protect, lut_wr_mac,
    input  lut_wr_ack
  );

  modport slave (
    output host_rd_req, host_rd_addr,
    input  host_rd_ack, host_rd_oq, host_rd_wr_protect, host_rd_mac,
    output host_wr_req, host_wr_addr, host_wr_oq, host_wr_protect, host_wr_mac,
    input  host_wr_ack,
    input  lut_rd_req, lut_rd_addr,
    output lut_rd_ack, lut_rd_oq, lut_rd_wr_protect, lut_rd_mac,
    input  lut_wr_req, lut_wr_addr, lut_wr_oq, lut_wr_protect, lut_wr_mac,
    output lut_wr_ack
  );
endinterface

// File: rtl/mac_lut_age_ctrl.sv
// MAC LUT aging controller: arbitrates host LUT access against a periodic age scan
// and evicts stale entries. Define MAC_LUT_AGE_STATS_EN to enable the aged_count counter.
module mac_lut_age_ctrl #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH_BITS    = 4,
  parameter int AGE_BITS          = 3,
  parameter int MAX_AGE           = 5,
  parameter int TICK_CYCLES       = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  mac_lut_age_ctrl_if.master        bus,
  input  logic                      refresh_valid,
  input  logic [LUT_DEPTH_BITS-1:0] refresh_addr,
  output logic                      aged_out,
  output logic                      scan_busy,
  output logic [31:0]               aged_count
);
  localparam int unsigned LUT_DEPTH = 2 ** LUT_DEPTH_BITS;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HOST_WR = 3'd1;
  localparam logic [2:0] HOST_RD = 3'd2;
  localparam logic [2:0] SCAN_RD = 3'd3;
  localparam logic [2:0] SCAN_WR = 3'd4;

  typedef logic [AGE_BITS-1:0] age_t;
  localparam age_t AGE_MAX = age_t'(MAX_AGE);
  localparam logic [LUT_DEPTH_BITS-1:0] SCAN_LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 2);

  logic [2:0]                state;
  logic [TICK_W-1:0]         tick_cnt;
  logic                      scan_pending;
  logic [LUT_DEPTH_BITS-1:0] scan_addr;
  age_t                      age [LUT_DEPTH];

  logic tick_wrap, wr_go, rd_go, refresh_hit, evict_done, scan_end;
  age_t age_cur;

  assign tick_wrap   = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  // The ack cycle still sees the host request held high; do not re-accept it.
  assign wr_go       = bus.host_wr_req && !bus.host_wr_ack;
  assign rd_go       = bus.host_rd_req && !bus.host_rd_ack;
  assign refresh_hit = refresh_valid && (refresh_addr == scan_addr);
  assign evict_done  = (state == SCAN_WR) && bus.lut_wr_ack;
  assign scan_end    = (scan_addr == SCAN_LAST);
  assign age_cur     = age[scan_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      tick_cnt               <= '0;
      scan_pending           <= 1'b0;
      scan_addr              <= '0;
      scan_busy              <= 1'b0;
      aged_out               <= 1'b0;
      bus.host_rd_ack        <= 1'b0;
      bus.host_rd_oq         <= '0;
      bus.host_rd_wr_protect <= 1'b0;
      bus.host_rd_mac        <= '0;
      bus.host_wr_ack        <= 1'b0;
      bus.lut_rd_req         <= 1'b0;
      bus.lut_rd_addr        <= '0;
      bus.lut_wr_req         <= 1'b0;
      bus.lut_wr_addr        <= '0;
      bus.lut_wr_oq          <= '0;
      bus.lut_wr_protect     <= 1'b0;
      bus.lut_wr_mac         <= '0;
      for (int unsigned i = 0; i < LUT_DEPTH; i++) age[i] <= '0;
    end else begin
      tick_cnt        <= tick_wrap ? '0 : tick_cnt + 1'b1;
      aged_out        <= evict_done;
      bus.host_wr_ack <= (state == HOST_WR) && bus.lut_wr_ack;
      bus.host_rd_ack <= (state == HOST_RD) && bus.lut_rd_ack;
      if (tick_wrap) scan_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_go) begin
            state              <= HOST_WR;
            bus.lut_wr_req     <= 1'b1;
            bus.lut_wr_addr    <= bus.host_wr_addr;
            bus.lut_wr_oq      <= bus.host_wr_oq;
            bus.lut_wr_protect <= bus.host_wr_protect;
            bus.lut_wr_mac     <= bus.host_wr_mac;
          end else if (rd_go) begin
            state           <= HOST_RD;
            bus.lut_rd_req  <= 1'b1;
            bus.lut_rd_addr <= bus.host_rd_addr;
          end else if (scan_busy) begin
            state           <= SCAN_RD;
            bus.lut_rd_req  <= 1'b1;
            bus.lut_rd_addr <= scan_addr;
          end else if (scan_pending) begin
            // Scan start issues the read of entry 0 in the same cycle; a
            // coincident tick wrap queues the following scan.
            scan_pending    <= tick_wrap;
            scan_busy       <= 1'b1;
            scan_addr       <= '0;
            state           <= SCAN_RD;
            bus.lut_rd_req  <= 1'b1;
            bus.lut_rd_addr <= '0;
          end
        end
        HOST_WR: begin
          if (bus.lut_wr_ack) begin
            bus.lut_wr_req       <= 1'b0;
            age[bus.lut_wr_addr] <= '0;
            state                <= IDLE;
          end
        end
        HOST_RD: begin
          if (bus.lut_rd_ack) begin
            bus.lut_rd_req         <= 1'b0;
            bus.host_rd_oq         <= bus.lut_rd_oq;
            bus.host_rd_wr_protect <= bus.lut_rd_wr_protect;
            bus.host_rd_mac        <= bus.lut_rd_mac;
            state                  <= IDLE;
          end
        end
        SCAN_RD: begin
          if (bus.lut_rd_ack) begin
            bus.lut_rd_req <= 1'b0;
            state          <= IDLE;
            if (bus.lut_rd_wr_protect || (bus.lut_rd_mac == 48'd0)) begin
              age[scan_addr] <= '0;
              if (scan_end) scan_busy <= 1'b0;
              else          scan_addr <= scan_addr + 1'b1;
            end else if ((age_cur == AGE_MAX) && !refresh_hit) begin
              state              <= SCAN_WR;
              bus.lut_wr_req     <= 1'b1;
              bus.lut_wr_addr    <= scan_addr;
              bus.lut_wr_oq      <= '0;
              bus.lut_wr_protect <= 1'b0;
              bus.lut_wr_mac     <= '0;
            end else begin
              age[scan_addr] <= (age_cur == AGE_MAX) ? age_cur : age_cur + 1'b1;
              if (scan_end) scan_busy <= 1'b0;
              else          scan_addr <= scan_addr + 1'b1;
            end
          end
        end
        SCAN_WR: begin
          if (bus.lut_wr_ack) begin
            bus.lut_wr_req <= 1'b0;
            age[scan_addr] <= '0;
            state          <= IDLE;
            if (scan_end) scan_busy <= 1'b0;
            else          scan_addr <= scan_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Last assignment so a refresh beats any same-cycle age update.
      if (refresh_valid) age[refresh_addr] <= '0;
    end
  end

`ifdef MAC_LUT_AGE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           aged_count <= '0;
    else if (evict_done) aged_count <= aged_count + 32'd1;
  end
`else
  assign aged_count = '0;
`endif

endmodule

// File: tb/tb_mac_lut_age_ctrl.sv
// Directed bench for mac_lut_age_ctrl: LUT responder model, host write/read table,
// and hand sequences for eviction, refresh, protection, interleave and reset.
module tb_mac_lut_age_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_lut_age_ctrl_if #(.NUM_OUTPUT_QUEUES(8), .LUT_DEPTH_BITS(4)) bus ();

  logic        refresh_valid;
  logic [3:0]  refresh_addr;
  logic        aged_out;
  logic        scan_busy;
  logic [31:0] aged_count;

  mac_lut_age_ctrl #(
    .NUM_OUTPUT_QUEUES(8),
    .LUT_DEPTH_BITS(4),
    .AGE_BITS(3),
    .MAX_AGE(2),
    .TICK_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .refresh_valid(refresh_valid),
    .refresh_addr(refresh_addr),
    .aged_out(aged_out),
    .scan_busy(scan_busy),
    .aged_count(aged_count)
  );

`ifdef MAC_LUT_AGE_STATS_EN
  localparam int EXP_AGED_COUNT = 1;
`else
  localparam int EXP_AGED_COUNT = 0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LUT contents, preload image and activity logs
  logic [47:0] mem_mac [16];
  logic [7:0]  mem_oq  [16];
  logic        mem_prot[16];
  logic [47:0] ld_mac  [16];
  logic [7:0]  ld_oq   [16];
  logic        ld_prot [16];
  logic lut_load = 1'b0;
  logic log_clr  = 1'b1;

  int rd_cnt[16];
  int wr_cnt[16];
  int aged_pulses = 0, hwa_cnt = 0, hra_cnt = 0, rd_issues = 0, rd_issue_at_wr = 0;
  int scans_started = 0, scans_done = 0, scan_reads = 0, last_scan_reads = 0, evict_scan = -1;
  logic [3:0]  last_wr_addr = '0;
  logic [47:0] last_wr_mac = '0;
  logic [7:0]  last_wr_oq = '0;
  logic        last_wr_prot = 1'b0;
  logic prev_busy = 1'b0, prev_rd_req = 1'b0, prev_wr_req = 1'b0;
  logic rd_fire, wr_fire;

  always @(posedge clk) begin
    rd_fire = bus.lut_rd_req && !bus.lut_rd_ack && !reset;
    wr_fire = bus.lut_wr_req && !bus.lut_wr_ack && !reset;
    bus.lut_rd_ack <= rd_fire;
    bus.lut_wr_ack <= wr_fire;
    if (rd_fire) begin
      bus.lut_rd_mac        <= mem_mac[bus.lut_rd_addr];
      bus.lut_rd_oq         <= mem_oq[bus.lut_rd_addr];
      bus.lut_rd_wr_protect <= mem_prot[bus.lut_rd_addr];
      rd_cnt[bus.lut_rd_addr] <= rd_cnt[bus.lut_rd_addr] + 1;
    end
    if (wr_fire) begin
      mem_mac[bus.lut_wr_addr]  <= bus.lut_wr_mac;
      mem_oq[bus.lut_wr_addr]   <= bus.lut_wr_oq;
      mem_prot[bus.lut_wr_addr] <= bus.lut_wr_protect;
      wr_cnt[bus.lut_wr_addr]   <= wr_cnt[bus.lut_wr_addr] + 1;
      last_wr_addr <= bus.lut_wr_addr;
      last_wr_mac  <= bus.lut_wr_mac;
      last_wr_oq   <= bus.lut_wr_oq;
      last_wr_prot <= bus.lut_wr_protect;
      if (bus.lut_wr_addr == 4'd3 && bus.lut_wr_mac == 48'd0) evict_scan <= scans_started;
    end
    if (lut_load) begin
      for (int i = 0; i < 16; i++) begin
        mem_mac[i]  <= ld_mac[i];
        mem_oq[i]   <= ld_oq[i];
        mem_prot[i] <= ld_prot[i];
      end
    end
    aged_pulses <= aged_pulses + int'(aged_out);
    hwa_cnt     <= hwa_cnt + int'(bus.host_wr_ack);
    hra_cnt     <= hra_cnt + int'(bus.host_rd_ack);
    prev_rd_req <= bus.lut_rd_req;
    prev_wr_req <= bus.lut_wr_req;
    if (bus.lut_rd_req && !prev_rd_req) rd_issues <= rd_issues + 1;
    if (bus.lut_wr_req && !prev_wr_req) rd_issue_at_wr <= rd_issues;
    prev_busy <= scan_busy;
    if (scan_busy && !prev_busy) begin
      scans_started <= scans_started + 1;
      scan_reads    <= int'(rd_fire);
    end else begin
      scan_reads <= scan_reads + int'(rd_fire && scan_busy);
    end
    if (!scan_busy && prev_busy) begin
      scans_done      <= scans_done + 1;
      last_scan_reads <= scan_reads;
    end
    if (log_clr) begin
      for (int i = 0; i < 16; i++) begin
        rd_cnt[i] <= 0;
        wr_cnt[i] <= 0;
      end
      aged_pulses <= 0; hwa_cnt <= 0; hra_cnt <= 0; rd_issues <= 0; rd_issue_at_wr <= 0;
      scans_started <= 0; scans_done <= 0; scan_reads <= 0; last_scan_reads <= 0;
      evict_scan <= -1;
    end
  end

  task automatic host_write(input logic [3:0] a, input logic [47:0] m, input logic [7:0] o,
                            input logic p);
    int n;
    @(negedge clk);
    bus.host_wr_req = 1'b1; bus.host_wr_addr = a; bus.host_wr_mac = m;
    bus.host_wr_oq = o; bus.host_wr_protect = p;
    n = 0;
    while (bus.host_wr_ack !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("host_wr_ack_seen", 64'(n < 400), 64'd1);
    bus.host_wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_read(input logic [3:0] a, output logic [47:0] m, output logic [7:0] o,
                           output logic p);
    int n;
    @(negedge clk);
    bus.host_rd_req = 1'b1; bus.host_rd_addr = a;
    n = 0;
    while (bus.host_rd_ack !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("host_rd_ack_seen", 64'(n < 400), 64'd1);
    m = bus.host_rd_mac; o = bus.host_rd_oq; p = bus.host_rd_wr_protect;
    bus.host_rd_req = 1'b0;
    @(negedge clk);
  endtask

  // Reset with a fresh LUT image and cleared logs, then release.
  task automatic restart();
    reset = 1'b1; lut_load = 1'b1; log_clr = 1'b1;
    repeat (3) @(negedge clk);
    lut_load = 1'b0; log_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic clear_image();
    for (int i = 0; i < 16; i++) begin ld_mac[i] = '0; ld_oq[i] = '0; ld_prot[i] = 1'b0; end
  endtask

  task automatic wait_scans(input int target, input string name);
    int n = 0;
    while (scans_done < target && n < 4000) begin @(negedge clk); n++; end
    check(name, 64'(n < 4000), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [47:0] mac;
    logic [7:0]  oq;
    logic        prot;
    logic [47:0] exp_mac;
    logic [7:0]  exp_oq;
    logic        exp_prot;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [47:0] rm;
    logic [7:0]  ro;
    logic        rp;
    int          n, snap_hwa, snap_hra, snap_rd;

    vecs[0] = '{4'd3,  48'h0011_2233_4455, 8'h04, 1'b0, 48'h0011_2233_4455, 8'h04, 1'b0};
    vecs[1] = '{4'd5,  48'hAABB_CCDD_EEFF, 8'h81, 1'b1, 48'hAABB_CCDD_EEFF, 8'h81, 1'b1};
    vecs[2] = '{4'd0,  48'h0000_0000_0001, 8'hFF, 1'b0, 48'h0000_0000_0001, 8'hFF, 1'b0};
    vecs[3] = '{4'd15, 48'hFFFF_FFFF_FFFF, 8'h01, 1'b1, 48'hFFFF_FFFF_FFFF, 8'h01, 1'b1};
    vecs[4] = '{4'd14, 48'h0200_0000_00FE, 8'h10, 1'b0, 48'h0200_0000_00FE, 8'h10, 1'b0};

    bus.host_rd_req = 1'b0; bus.host_rd_addr = '0;
    bus.host_wr_req = 1'b0; bus.host_wr_addr = '0; bus.host_wr_oq = '0;
    bus.host_wr_protect = 1'b0; bus.host_wr_mac = '0;
    refresh_valid = 1'b0; refresh_addr = '0;
    clear_image();

    reset = 1'b1; lut_load = 1'b1; log_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lut_rd_req", 64'(bus.lut_rd_req), 64'd0);
    check("rst_lut_wr_req", 64'(bus.lut_wr_req), 64'd0);
    check("rst_host_wr_ack", 64'(bus.host_wr_ack), 64'd0);
    check("rst_host_rd_ack", 64'(bus.host_rd_ack), 64'd0);
    check("rst_host_rd_mac", 64'(bus.host_rd_mac), 64'd0);
    check("rst_scan_busy", 64'(scan_busy), 64'd0);
    check("rst_aged_out", 64'(aged_out), 64'd0);
    check("rst_aged_count", 64'(aged_count), 64'd0);
    lut_load = 1'b0; log_clr = 1'b0; reset = 1'b0;

    // Host write / read-back table, scans running in the background
    for (int v = 0; v < 5; v++) begin
      snap_hwa = hwa_cnt;
      host_write(vecs[v].addr, vecs[v].mac, vecs[v].oq, vecs[v].prot);
      check("lut_wr_addr", 64'(last_wr_addr), 64'(vecs[v].addr));
      check("lut_wr_mac", 64'(last_wr_mac), 64'(vecs[v].exp_mac));
      check("lut_wr_oq", 64'(last_wr_oq), 64'(vecs[v].exp_oq));
      check("lut_wr_protect", 64'(last_wr_prot), 64'(vecs[v].exp_prot));
      check("host_wr_ack_pulses", 64'(hwa_cnt - snap_hwa), 64'd1);
      snap_hra = hra_cnt;
      host_read(vecs[v].addr, rm, ro, rp);
      check("host_rd_mac", 64'(rm), 64'(vecs[v].exp_mac));
      check("host_rd_oq", 64'(ro), 64'(vecs[v].exp_oq));
      check("host_rd_protect", 64'(rp), 64'(vecs[v].exp_prot));
      check("host_rd_ack_pulses", 64'(hra_cnt - snap_hra), 64'd1);
    end
    check("host_rd_data_held", 64'(bus.host_rd_mac), 64'h0200_0000_00FE);

    // Reset while a LUT read is outstanding
    n = 0;
    while (bus.lut_rd_req !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("lut_rd_req_seen", 64'(n < 400), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_lut_rd_req", 64'(bus.lut_rd_req), 64'd0);
    check("midrst_scan_busy", 64'(scan_busy), 64'd0);
    check("midrst_aged_count", 64'(aged_count), 64'd0);

    // Eviction / protect / broadcast: 3 valid, 5 protected, 15 never scanned
    clear_image();
    ld_mac[3] = 48'h0011_2233_4455; ld_oq[3] = 8'h04;
    ld_mac[5] = 48'hAABB_CCDD_EEFF; ld_oq[5] = 8'h81; ld_prot[5] = 1'b1;
    ld_mac[15] = 48'hFFFF_FFFF_FFFF; ld_oq[15] = 8'hFF;
    @(negedge clk);
    restart();
    wait_scans(10, "evict_scans_done");
    check("evict_wr_cnt_3", 64'(wr_cnt[3]), 64'd1);
    check("evict_on_scan", 64'(evict_scan), 64'd3);
    check("evict_mem_mac_3", 64'(mem_mac[3]), 64'd0);
    check("evict_aged_pulses", 64'(aged_pulses), 64'd1);
    check("evict_aged_count", 64'(aged_count), 64'(EXP_AGED_COUNT));
    check("protect_wr_cnt_5", 64'(wr_cnt[5]), 64'd0);
    check("bcast_rd_cnt_15", 64'(rd_cnt[15]), 64'd0);
    check("scan_rd_cnt_14", 64'(rd_cnt[14]), 64'd10);

    // Refresh every 10 cycles keeps entry 3 alive
    clear_image();
    ld_mac[3] = 48'h0011_2233_4455; ld_oq[3] = 8'h04;
    restart();
    n = 0;
    while (scans_done < 10 && n < 4000) begin
      @(negedge clk);
      refresh_addr  = 4'd3;
      refresh_valid = (n % 10 == 0);
      n++;
    end
    refresh_valid = 1'b0;
    check("refresh_scans_done", 64'(n < 4000), 64'd1);
    check("refresh_wr_cnt_3", 64'(wr_cnt[3]), 64'd0);
    check("refresh_aged_pulses", 64'(aged_pulses), 64'd0);
    check("refresh_rd_cnt_3", 64'(rd_cnt[3]), 64'd10);

    // Host write raised mid-scan goes ahead of the next scan step
    clear_image();
    restart();
    n = 0;
    while (!(bus.lut_rd_req === 1'b1 && scan_busy === 1'b1) && n < 400) begin
      @(negedge clk); n++;
    end
    check("scan_rd_seen", 64'(n < 400), 64'd1);
    @(negedge clk);
    snap_rd  = rd_issues;
    snap_hwa = hwa_cnt;
    host_write(4'd9, 48'h0A0B_0C0D_0E0F, 8'h22, 1'b0);
    check("interleave_no_scan_rd", 64'(rd_issue_at_wr), 64'(snap_rd));
    check("interleave_wr_addr", 64'(last_wr_addr), 64'd9);
    check("interleave_wr_mac", 64'(last_wr_mac), 64'h0A0B_0C0D_0E0F);
    check("interleave_wr_ack", 64'(hwa_cnt - snap_hwa), 64'd1);
    wait_scans(1, "interleave_scan_done");
    check("interleave_scan_reads", 64'(last_scan_reads), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
